// File: rtl/rewind_sequencer_pkg.sv
// Shared types for the mispredict rewind sequencer: ROB/physical tag widths and walk states.
package rewind_sequencer_pkg;
    localparam int DEF_WAY      = 2;
    localparam int DEF_ROB_SIZE = 8;
    localparam int ROB_IDX_W    = $clog2(DEF_ROB_SIZE);
    localparam int PHY_REG_W    = 6;

    typedef logic [ROB_IDX_W-1:0] rob_idx_t;
    typedef logic [PHY_REG_W-1:0] phy_reg_idx_t;

    typedef enum logic [1:0] {IDLE, WALK, DONE} rewind_state_e;
endpackage

// File: rtl/rewind_sequencer_if.sv
// Bundle between the rewind sequencer and its surroundings (ROB, map table, freelist, dispatch).
interface rewind_sequencer_if
    import rewind_sequencer_pkg::*;
#(
    parameter int WAY      = DEF_WAY,
    parameter int ROB_SIZE = DEF_ROB_SIZE
) ();
    localparam int IDX_W = $clog2(ROB_SIZE);
    localparam int CNT_W = $clog2(WAY + 1);

    logic                             squash_valid;
    logic [IDX_W-1:0]                 squash_rob_idx;
    logic [IDX_W-1:0]                 rob_head;
    logic [IDX_W-1:0]                 rob_tail;
    logic [WAY-1:0][IDX_W-1:0]        rob_rd_idx;
    logic [WAY-1:0]                   rob_rd_has_dest;
    logic [WAY-1:0][PHY_REG_W-1:0]    rob_rd_T;
    logic [WAY-1:0][PHY_REG_W-1:0]    rob_rd_Told;
    logic [CNT_W-1:0]                 rewind_num;
    logic [WAY-1:0][PHY_REG_W-1:0]    rewind_T;
    logic [WAY-1:0][PHY_REG_W-1:0]    rewind_Told;
    logic [CNT_W-1:0]                 free_num;
    logic [WAY-1:0][PHY_REG_W-1:0]    free_tag;
    logic                             dispatch_stall;
    logic                             tail_set_valid;
    logic [IDX_W-1:0]                 tail_set_idx;

    modport master (
        input  squash_valid, squash_rob_idx, rob_head, rob_tail,
               rob_rd_has_dest, rob_rd_T, rob_rd_Told,
        output rob_rd_idx, rewind_num, rewind_T, rewind_Told, free_num, free_tag,
               dispatch_stall, tail_set_valid, tail_set_idx
    );

    modport slave (
        output squash_valid, squash_rob_idx, rob_head, rob_tail,
               rob_rd_has_dest, rob_rd_T, rob_rd_Told,
        input  rob_rd_idx, rewind_num, rewind_T, rewind_Told, free_num, free_tag,
               dispatch_stall, tail_set_valid, tail_set_idx
    );
endinterface

// File: rtl/rewind_sequencer_compactor.sv
// Order-preserving packing of WAY (valid, T, Told) lanes into a dense prefix plus a count.
module rewind_sequencer_compactor #(
    parameter int WAY   = 2,
    parameter int TAG_W = 6,
    parameter int CNT_W = $clog2(WAY + 1)
) (
    input  logic [WAY-1:0]             in_vld,
    input  logic [WAY-1:0][TAG_W-1:0]  in_t,
    input  logic [WAY-1:0][TAG_W-1:0]  in_told,
    output logic [CNT_W-1:0]           out_num,
    output logic [WAY-1:0][TAG_W-1:0]  out_t,
    output logic [WAY-1:0][TAG_W-1:0]  out_told
);
    logic [WAY-1:0][CNT_W-1:0] pre;

    always_comb begin
        pre[0] = '0;
        for (int i = 1; i < WAY; i++) begin
            pre[i] = pre[i-1] + CNT_W'(in_vld[i-1]);
        end
        out_num = pre[WAY-1] + CNT_W'(in_vld[WAY-1]);
    end

    // A valid input lane lands on the output lane equal to its prefix count.
    always_comb begin
        out_t    = '0;
        out_told = '0;
        for (int j = 0; j < WAY; j++) begin
            for (int i = 0; i < WAY; i++) begin
                if (in_vld[i] && pre[i] == CNT_W'(j)) begin
                    out_t[j]    = in_t[i];
                    out_told[j] = in_told[i];
                end
            end
        end
    end
endmodule

// File: rtl/rewind_sequencer.sv
// Mispredict recovery: walks the ROB youngest-first from tail to the branch, replaying
// (T, Told) pairs to the map table and freelist, then publishes the restored tail.
module rewind_sequencer
    import rewind_sequencer_pkg::*;
#(
    parameter int WAY      = DEF_WAY,
    parameter int ROB_SIZE = DEF_ROB_SIZE
) (
    input  logic                clock,
    input  logic                reset,
    rewind_sequencer_if.master  bus
);
    localparam int IDX_W = $clog2(ROB_SIZE);
    localparam int CNT_W = $clog2(WAY + 1);

    typedef logic [IDX_W-1:0] idx_t;
    localparam idx_t WAY_I = idx_t'(WAY);

    rewind_state_e state_q, state_d;
    idx_t          cursor_q, cursor_d;
    idx_t          stop_q, stop_d;
    idx_t          remain_q, remain_d;
    logic          pend_q, pend_d;
    idx_t          pend_idx_q, pend_idx_d;

    idx_t                             n;
    idx_t                             sq_idx;
    logic [WAY-1:0]                   lane_vld;
    logic [WAY-1:0][IDX_W-1:0]        rd_idx;
    logic                             tail_set_valid;
    idx_t                             tail_set_idx;
    logic [CNT_W-1:0]                 rw_num;
    logic [WAY-1:0][PHY_REG_W-1:0]    rw_t;
    logic [WAY-1:0][PHY_REG_W-1:0]    rw_told;

    // Age relative to the ROB head; smaller means older.
    function automatic idx_t age(input idx_t x, input idx_t head);
        return x - head;
    endfunction

    always_comb begin
        state_d        = state_q;
        cursor_d       = cursor_q;
        stop_d         = stop_q;
        remain_d       = remain_q;
        pend_d         = pend_q;
        pend_idx_d     = pend_idx_q;
        n              = '0;
        lane_vld       = '0;
        rd_idx         = '0;
        tail_set_valid = 1'b0;
        tail_set_idx   = '0;

        // A squash deferred from DONE competes with a fresh one; the older branch wins.
        sq_idx = bus.squash_rob_idx;
        if (pend_q && (!bus.squash_valid ||
                       age(pend_idx_q, bus.rob_head) < age(bus.squash_rob_idx, bus.rob_head)))
            sq_idx = pend_idx_q;

        case (state_q)
            IDLE: begin
                pend_d = 1'b0;
                if (bus.squash_valid || pend_q) begin
                    stop_d   = sq_idx + idx_t'(1);
                    cursor_d = bus.rob_tail - idx_t'(1);
                    remain_d = bus.rob_tail - stop_d;
                    state_d  = (remain_d != '0) ? WALK : DONE;
                end
            end
            WALK: begin
                n = (remain_q < WAY_I) ? remain_q : WAY_I;
                for (int i = 0; i < WAY; i++) begin
                    if (idx_t'(i) < n) begin
                        rd_idx[i]   = cursor_q - idx_t'(i);
                        lane_vld[i] = bus.rob_rd_has_dest[i];
                    end
                end
                cursor_d = cursor_q - n;
                remain_d = remain_q - n;
                state_d  = (remain_q == n) ? DONE : WALK;
                // An older branch pulls the stop point back; this cycle's lanes still issue.
                if (bus.squash_valid &&
                    age(bus.squash_rob_idx, bus.rob_head) < age(stop_q - idx_t'(1), bus.rob_head)) begin
                    stop_d   = bus.squash_rob_idx + idx_t'(1);
                    remain_d = cursor_d + idx_t'(1) - stop_d;
                    state_d  = (remain_d != '0) ? WALK : DONE;
                end
            end
            DONE: begin
                tail_set_valid = 1'b1;
                tail_set_idx   = stop_q;
                state_d        = IDLE;
                if (bus.squash_valid) begin
                    pend_d     = 1'b1;
                    pend_idx_d = bus.squash_rob_idx;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cursor_q   <= '0;
            stop_q     <= '0;
            remain_q   <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            cursor_q   <= cursor_d;
            stop_q     <= stop_d;
            remain_q   <= remain_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
        end
    end

    rewind_sequencer_compactor #(
        .WAY   (WAY),
        .TAG_W (PHY_REG_W),
        .CNT_W (CNT_W)
    ) u_compactor (
        .in_vld   (lane_vld),
        .in_t     (bus.rob_rd_T),
        .in_told  (bus.rob_rd_Told),
        .out_num  (rw_num),
        .out_t    (rw_t),
        .out_told (rw_told)
    );

    assign bus.rob_rd_idx     = rd_idx;
    assign bus.rewind_num     = rw_num;
    assign bus.rewind_T       = rw_t;
    assign bus.rewind_Told    = rw_told;
    assign bus.free_num       = rw_num;
    assign bus.free_tag       = rw_t;
    assign bus.dispatch_stall = (state_q != IDLE);
    assign bus.tail_set_valid = tail_set_valid;
    assign bus.tail_set_idx   = tail_set_idx;
endmodule
